// File: rtl/mprj_pad_cfg_loader_if.sv
// Register-side and chain-side signal bundle for the pad drive-mode loader.
interface mprj_pad_cfg_loader_if;
  logic       cfg_we;
  logic [5:0] cfg_addr;
  logic [2:0] cfg_wdata;
  logic [2:0] cfg_rdata;
  logic       wr_err;
  logic       load_req;
  logic       load_busy;
  logic       load_done;
  logic       ser_clk;
  logic       ser_data;
  logic       ser_load;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, load_req,
    input  cfg_rdata, wr_err, load_busy, load_done,
    input  ser_clk, ser_data, ser_load
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, load_req,
    output cfg_rdata, wr_err, load_busy, load_done,
    output ser_clk, ser_data, ser_load
  );
endinterface

// File: rtl/mprj_pad_cfg_loader.sv
// Pad DM bank plus serial shift/latch loader for the padframe control chain.
// Optional PAD_CFG_AUTOLOAD_EN: load the default bank right after reset.
module mprj_pad_cfg_loader #(
  parameter int NUM_PADS = 38,
  parameter int DM_W     = 3,
  parameter int CLK_DIV  = 2
) (
  input logic clock,
  input logic resetn,
  mprj_pad_cfg_loader_if.slave bus
);

  localparam int NB  = NUM_PADS * DM_W;
  localparam int BW  = $clog2(NB);
  localparam int PER = 2 * CLK_DIV;
  localparam int PW  = $clog2(PER + 1);
  localparam int AW  = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH,
    DONE
  } state_t;

  state_t          state;
  logic [DM_W-1:0] bank [NUM_PADS];
  logic [NB-1:0]   flat;
  logic [BW-1:0]   bitcnt;
  logic [PW-1:0]   phase;
  logic            pending;
  logic            in_range;
  logic            wr_ok;
  logic            start;
  logic [AW-1:0]   idx;
  logic [DM_W-1:0] wval;
`ifdef PAD_CFG_AUTOLOAD_EN
  logic            boot;
`endif

  assign in_range = {26'd0, bus.cfg_addr} < 32'(NUM_PADS);
  assign idx      = bus.cfg_addr[AW-1:0];
  assign wr_ok    = bus.cfg_we & in_range & (state == IDLE);
  assign start    = bus.load_req | pending;

  always_comb begin
    bus.cfg_rdata = '0;
    if (in_range) bus.cfg_rdata = bank[idx];
  end

  // Unsupported modes fall back to plain input.
  always_comb begin
    wval = DM_W'(1);
    unique case (bus.cfg_wdata)
      DM_W'(1), DM_W'(2), DM_W'(3), DM_W'(6): wval = bus.cfg_wdata;
      default: wval = DM_W'(1);
    endcase
  end

  // Bit b of the stream is pad b/DM_W, mode bit b%DM_W.
  always_comb begin
    flat = '0;
    for (int p = 0; p < NUM_PADS; p++)
      flat[p*DM_W +: DM_W] = bank[p];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      pending       <= 1'b0;
      bitcnt        <= '0;
      phase         <= '0;
      bus.ser_clk   <= 1'b0;
      bus.ser_data  <= 1'b0;
      bus.ser_load  <= 1'b0;
      bus.load_busy <= 1'b0;
      bus.load_done <= 1'b0;
      bus.wr_err    <= 1'b0;
      for (int i = 0; i < NUM_PADS; i++)
        bank[i] <= DM_W'(1);
`ifdef PAD_CFG_AUTOLOAD_EN
      boot          <= 1'b1;
`endif
    end else begin
      bus.wr_err    <= bus.cfg_we & ~wr_ok;
      bus.load_done <= 1'b0;
      if (wr_ok) bank[idx] <= wval;
      if (state != IDLE && bus.load_req) pending <= 1'b1;
      unique case (state)
        IDLE: begin
          if (start) begin
            state         <= SHIFT;
            pending       <= 1'b0;
            bus.load_busy <= 1'b1;
            bitcnt        <= BW'(NB - 1);
            phase         <= '0;
            bus.ser_clk   <= 1'b0;
            bus.ser_data  <= flat[NB-1];
          end
        end
        SHIFT: begin
          if (phase == PW'(PER - 1)) begin
            phase       <= '0;
            bus.ser_clk <= 1'b0;
            if (bitcnt == '0) begin
              state        <= LATCH;
              bus.ser_data <= 1'b0;
              bus.ser_load <= 1'b1;
            end else begin
              bitcnt       <= bitcnt - 1'b1;
              bus.ser_data <= flat[bitcnt - 1'b1];
            end
          end else begin
            phase       <= phase + 1'b1;
            bus.ser_clk <= (phase + 1'b1) >= PW'(CLK_DIV);
          end
        end
        LATCH: begin
          if (phase == PW'(PER - 1)) begin
            phase         <= '0;
            bus.ser_load  <= 1'b0;
            bus.load_done <= 1'b1;
            state         <= DONE;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        DONE: begin
          bus.load_busy <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef PAD_CFG_AUTOLOAD_EN
      if (boot) begin
        boot    <= 1'b0;
        pending <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mprj_pad_cfg_loader.sv
// Randomized bench for mprj_pad_cfg_loader against a pad-level mode model.
module tb_mprj_pad_cfg_loader;
  localparam int NP = 38;
  localparam int NB = NP * 3;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  mprj_pad_cfg_loader_if bus();

  mprj_pad_cfg_loader dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;
  int   ndone = 0;
  int   nbusy = 0;
  int   lcyc = 0;
  int   acc = 0;
  logic pclk = 1'b0;
  logic [2:0] mdl [NP];
  bit   cap [$];
  bit   exp_q [$];
  int   done_at [$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [2:0] coerce(input logic [2:0] d);
    return (d == 3'd1 || d == 3'd2 || d == 3'd3 || d == 3'd6) ? d : 3'd1;
  endfunction

  always @(posedge clock) begin
    #2;
    cyc++;
    if (bus.ser_clk && !pclk) cap.push_back(bus.ser_data);
    pclk = bus.ser_clk;
    if (bus.ser_load) lcyc++;
    if (bus.load_busy) nbusy++;
    if (bus.load_done) begin
      ndone++;
      done_at.push_back(cyc);
    end
  end

  task automatic wr(input int a, input logic [2:0] d, input bit busy);
    bit bad;
    bad = busy || a >= NP;
    @(negedge clock);
    bus.cfg_we = 1'b1;
    bus.cfg_addr = 6'(a);
    bus.cfg_wdata = d;
    @(negedge clock);
    bus.cfg_we = 1'b0;
    chk("wr_err", 32'(bus.wr_err), 32'(bad));
    if (!bad) mdl[a] = coerce(d);
    #1;
    chk("rdback", 32'(bus.cfg_rdata), a < NP ? 32'(mdl[a]) : 32'd0);
  endtask

  task automatic start_load();
    @(negedge clock);
    for (int p = NP - 1; p >= 0; p--)
      for (int b = 2; b >= 0; b--) exp_q.push_back(mdl[p][b]);
    acc = cyc;
    bus.load_req = 1'b1;
    @(negedge clock);
    bus.load_req = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int k = 0;
    while (ndone < n && k < 3000) begin
      @(negedge clock);
      k++;
    end
    if (ndone < n) chk("done_timeout", 32'(ndone), 32'(n));
  endtask

  task automatic cmp_stream(input string tag);
    int bad = 0;
    chk({tag, "_len"}, 32'(cap.size()), 32'(exp_q.size()));
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
      if (cap[i] != exp_q[i]) bad++;
    chk({tag, "_bits"}, 32'(bad), 32'd0);
  endtask

  task automatic chk_bank(input string tag);
    int bad = 0;
    for (int a = 0; a < NP; a++) begin
      bus.cfg_addr = 6'(a);
      #1;
      if (bus.cfg_rdata !== mdl[a]) bad++;
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  function automatic logic [5:0] outs();
    return {bus.ser_clk, bus.ser_data, bus.ser_load,
            bus.load_busy, bus.load_done, bus.wr_err};
  endfunction

  initial begin
    int nd, nb0;
    bus.cfg_we = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_wdata = '0;
    bus.load_req = 1'b0;
    for (int i = 0; i < NP; i++) mdl[i] = 3'd1;

    // reset state
    repeat (3) @(negedge clock);
    chk("rst_outs", 32'(outs()), 32'd0);
    resetn = 1'b1;
`ifdef PAD_CFG_AUTOLOAD_EN
    exp_q.delete();
    cap.delete();
    for (int i = 0; i < NB; i++) exp_q.push_back(i % 3 == 2);
    wait_done(1);
    cmp_stream("autoload");
    repeat (2) @(negedge clock);
`endif
    for (int a = 0; a < NP; a++) begin
      bus.cfg_addr = 6'(a);
      #1;
      chk("rst_rd", 32'(bus.cfg_rdata), 32'd1);
    end
    bus.cfg_addr = 6'd40;
    #1;
    chk("rd_oor", 32'(bus.cfg_rdata), 32'd0);
    chk("idle_outs", 32'(outs()), 32'd0);

    // directed load
    wr(5, 3'b110, 0);
    wr(37, 3'b011, 0);
    wr(0, 3'b010, 0);
    cap.delete();
    exp_q.delete();
    lcyc = 0;
    start_load();
    wait_done(ndone + 1);
    chk("dir_busy_at_done", 32'(bus.load_busy), 32'd1);
    cmp_stream("dir");
    chk("dir_first", {29'd0, cap[0], cap[1], cap[2]}, 32'b011);
    chk("dir_last", {29'd0, cap[111], cap[112], cap[113]}, 32'b010);
    chk("dir_pad5", {29'd0, cap[96], cap[97], cap[98]}, 32'b110);
    chk("dir_done_cyc", 32'(done_at[$] - acc), 32'd461);
    chk("dir_latch", 32'(lcyc), 32'd4);
    @(negedge clock);
    chk("dir_busy_drop", 32'(bus.load_busy), 32'd0);

    // coercion and out-of-range writes
    wr(3, 3'b111, 0);
    wr(38, 3'b110, 0);
    @(negedge clock);
    chk("err_pulse_1cyc", 32'(bus.wr_err), 32'd0);
    chk_bank("bank_after_oor");

    // random writes then load
    for (int i = 0; i < 40; i++)
      wr($urandom_range(0, 45), 3'($urandom_range(0, 7)), 0);
    cap.delete();
    exp_q.delete();
    lcyc = 0;
    start_load();
    wait_done(ndone + 1);
    cmp_stream("rand");
    chk("rand_done_cyc", 32'(done_at[$] - acc), 32'd461);

    // write during shift is dropped
    cap.delete();
    exp_q.delete();
    nd = ndone;
    start_load();
    for (int k = 0; k < 500 && cap.size() < 10; k++) @(negedge clock);
    wr(2, 3'b110, 1);
    wait_done(nd + 1);
    cmp_stream("busywr");
    chk_bank("bank_after_busywr");

    // coalesced requests
    cap.delete();
    exp_q.delete();
    nd = ndone;
    start_load();
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(20, 100)) @(negedge clock);
      bus.load_req = 1'b1;
      @(negedge clock);
      bus.load_req = 1'b0;
    end
    for (int p = NP - 1; p >= 0; p--)
      for (int b = 2; b >= 0; b--) exp_q.push_back(mdl[p][b]);
    wait_done(nd + 2);
    repeat (600) @(negedge clock);
    chk("coal_ndone", 32'(ndone - nd), 32'd2);
    chk("coal_gap", 32'(done_at[$] - done_at[$-1]), 32'd462);
    cmp_stream("coal");

    // reset in the middle of a shift
    cap.delete();
    exp_q.delete();
    lcyc = 0;
    start_load();
    for (int k = 0; k < 1000 && cap.size() < 50; k++) @(negedge clock);
    chk("mid_bits", 32'(cap.size()), 32'd50);
    #1 resetn = 1'b0;
    #1;
    chk("mid_rst_outs", 32'(outs()), 32'd0);
    for (int i = 0; i < NP; i++) mdl[i] = 3'd1;
    chk_bank("mid_rst_bank");
    chk("mid_no_latch", 32'(lcyc), 32'd0);
    repeat (2) @(negedge clock);
    cap.delete();
    nd = ndone;
    nb0 = nbusy;
    resetn = 1'b1;
`ifdef PAD_CFG_AUTOLOAD_EN
    for (int i = 0; i < NB; i++) exp_q.push_back(i % 3 == 2);
    wait_done(nd + 1);
    cmp_stream("post_rst_auto");
`else
    repeat (600) @(negedge clock);
    chk("post_rst_busy", 32'(nbusy - nb0), 32'd0);
    chk("post_rst_done", 32'(ndone - nd), 32'd0);
    chk("post_rst_lat", 32'(lcyc), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mprj_pad_cfg_loader.md
Name: mprj_pad_cfg_loader

Overview:
- Holds the DM[2:0] drive-mode word for every user-project pad and serially loads them into the pad-control shift chain that feeds the padframe DM inputs.
- Sits between the housekeeping register interface and the padframe.
- Sequences the load as shift, then latch strobe, then done.
- Validates modes against the pad-supported set: 001 input, 010 input+pullup, 011 input+pulldown, 110 output.

Parameters:
- NUM_PADS, 38, number of pads in the chain (1..64).
- DM_W, 3, mode bits per pad.
- CLK_DIV, 2, half-period of ser_clk in clock cycles (>=1).

Ports:
- clock  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- cfg_we  input  1  write strobe for mode bank.
- cfg_addr  input  6  pad index.
- cfg_wdata  input  3  mode to write.
- cfg_rdata  output  3  mode bank readback at cfg_addr (combinational).
- wr_err  output  1  one-cycle pulse on a rejected write.
- load_req  input  1  request a chain load (level sampled each cycle).
- load_busy  output  1  high from the cycle after acceptance until load_done.
- load_done  output  1  one-cycle pulse at end of load.
- ser_clk  output  1  chain shift clock.
- ser_data  output  1  chain serial data.
- ser_load  output  1  chain parallel-latch strobe.

Behaviour:
- Reset (asynchronous, resetn=0):
  - every bank entry = 3'b001.
  - FSM = IDLE; pending = 0.
  - ser_clk, ser_data, ser_load, load_busy, load_done, wr_err all = 0.
- Writes:
  - Accepted only in IDLE with cfg_addr < NUM_PADS; the bank updates on the next clock edge.
  - cfg_wdata not in {001,010,011,110} is stored as 001 (coerced); not flagged as an error.
  - Writes while busy, or with cfg_addr >= NUM_PADS: dropped, wr_err=1 for the following cycle.
- Reads: cfg_rdata = bank[cfg_addr] when in range, else 3'b000.
- FSM states: IDLE -> SHIFT -> LATCH -> DONE -> IDLE.
- IDLE:
  - load_req=1 or pending=1 -> SHIFT next cycle; load_busy=1; pending cleared.
  - bit counter = NUM_PADS*DM_W-1; phase counter = 0.
- SHIFT:
  - Order: pad NUM_PADS-1 first; within a pad, DM[2] first. Last bit is pad 0 DM[0].
  - Each bit occupies 2*CLK_DIV cycles.
  - ser_data is valid for the whole bit period.
  - ser_clk is 0 for the first CLK_DIV cycles and 1 for the last CLK_DIV cycles. The chain samples on the rising edge.
  - After the last bit's period: ser_clk=0, go to LATCH.
- LATCH: ser_load=1 for exactly 2*CLK_DIV cycles; ser_data=0.
- DONE: single cycle.
  - load_done=1; load_busy drops to 0 on the next cycle.
  - Returns to IDLE.
- Shift duration: total SHIFT cycles = NUM_PADS*DM_W*2*CLK_DIV. With defaults: 456 SHIFT + 4 LATCH + 1 DONE.
- load_req asserted while busy:
  - sets pending (single-depth; extra requests coalesce).
  - A pending load starts on the cycle after DONE.
  - load_req and load_done in the same cycle: counts as pending.
- Shift data source: the bank is frozen while busy, so the shifted data equals bank contents at acceptance.
- Reset mid-load: outputs return to their reset values immediately. The chain latch is not strobed, so pads retain their previous latched modes.
- ser_clk, ser_data, ser_load are registered outputs (glitch-free).

Optional Feature:
- Macro: PAD_CFG_AUTOLOAD_EN.
- Defined: the first clock after resetn deasserts sets pending=1, so the default bank (all 001) is loaded without load_req. load_busy is high from cycle 2 after reset release.
- Undefined: no load occurs until load_req.

Test Plan:
- Reset, read all 38 addresses -> cfg_rdata=3'b001 each; read addr 40 -> 3'b000; ser_* all 0.
- Write pad5=110, pad37=011, pad0=010, then pulse load_req:
  - captured stream = 114 bits, first three 0,1,1 (pad37), last three 0,1,0 (pad0), pad5 bits read 1,1,0.
  - ser_load high 4 cycles; load_done at cycle 461 after acceptance.
- Write 3'b111 to pad3 -> readback 001, no wr_err. Write to addr 38 -> wr_err one cycle, bank unchanged.
- Write pad2=110 during SHIFT -> wr_err pulse, pad2 still 001, streamed bits unaffected.
- load_req pulsed 3 times during a load -> exactly one extra load starts the cycle after load_done; two load_done pulses total.
- Assert resetn=0 at SHIFT bit 50 -> all outputs 0 within the same cycle, no ser_load pulse, bank reset to 001. With PAD_CFG_AUTOLOAD_EN defined, a full all-001 load follows automatically.
